// File: rtl/bcpu_defs_pkg.sv
// Shared bcpu definitions: flag bit positions, ALU latency and the
// writeback tag carried alongside each in-flight ALU op.
package bcpu_defs;

    localparam int unsigned FLAG_C = 0;
    localparam int unsigned FLAG_Z = 1;
    localparam int unsigned FLAG_S = 2;
    localparam int unsigned FLAG_V = 3;

    localparam int unsigned ALU_LATENCY = 3;
    localparam int unsigned REG_ADDR_W  = 3;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] dest;
        logic                  wr_reg;
        logic                  wr_flags;
    } alu_wb_tag_t;

endpackage

// File: rtl/bcpu_alu_wb_tagpipe.sv
// CE-gated tag shift register that runs in lockstep with the ALU pipeline;
// stage[DEPTH-1] describes the result currently on ALU_OUT.
module bcpu_alu_wb_tagpipe
    import bcpu_defs::*;
#(
    parameter int unsigned DEPTH = ALU_LATENCY
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    CE,
    input  alu_wb_tag_t             issue_tag,
    output alu_wb_tag_t [DEPTH-1:0] stage
);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            stage <= '0;
        end else if (CE) begin
            stage[0] <= issue_tag;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

endmodule

// File: rtl/bcpu_alu_writeback.sv
// Writeback end of the bcpu ALU pipeline: register-file commit, architectural
// flags, RAW hazard / bypass reporting and in-flight op count.
module bcpu_alu_writeback
    import bcpu_defs::*;
#(
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned REG_ADDR_WIDTH = REG_ADDR_W,
    parameter int unsigned PIPE_DEPTH     = ALU_LATENCY
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      CE,
    input  logic                      ISSUE_EN,
    input  logic [REG_ADDR_WIDTH-1:0] ISSUE_DEST,
    input  logic                      ISSUE_WR_REG,
    input  logic                      ISSUE_WR_FLAGS,
    input  logic [REG_ADDR_WIDTH-1:0] SRC_A_ADDR,
    input  logic [REG_ADDR_WIDTH-1:0] SRC_B_ADDR,
    input  logic [DATA_WIDTH-1:0]     ALU_OUT,
    input  logic [3:0]                FLAGS_OUT,
    output logic                      REG_WE,
    output logic [REG_ADDR_WIDTH-1:0] REG_WADDR,
    output logic [DATA_WIDTH-1:0]     REG_WDATA,
    output logic [3:0]                FLAGS_REG,
    output logic [3:0]                FLAGS_NEXT,
    output logic                      HAZARD,
    output logic                      BYPASS_A,
    output logic                      BYPASS_B,
    output logic [1:0]                PENDING_CNT
);

    alu_wb_tag_t                   issue_tag;
    alu_wb_tag_t [PIPE_DEPTH-1:0]  stage;
    alu_wb_tag_t                   retire;
    logic                          commit;
    logic                          raw_hazard;
    logic                          flag_hazard;

    always_comb begin
        issue_tag          = '0;
        issue_tag.valid    = ISSUE_EN;
        issue_tag.dest     = ISSUE_DEST;
        issue_tag.wr_reg   = ISSUE_WR_REG;
        issue_tag.wr_flags = ISSUE_WR_FLAGS;
    end

    bcpu_alu_wb_tagpipe #(
        .DEPTH(PIPE_DEPTH)
    ) u_tagpipe (
        .CLK      (CLK),
        .RESET    (RESET),
        .CE       (CE),
        .issue_tag(issue_tag),
        .stage    (stage)
    );

    assign retire = stage[PIPE_DEPTH-1];

    // Reset also blocks the retiring write so flushed ops never reach the register file.
    assign commit    = CE & ~RESET & retire.valid;
    assign REG_WE    = commit & retire.wr_reg;
    assign REG_WADDR = retire.dest;
    assign REG_WDATA = ALU_OUT;

    assign FLAGS_NEXT = (retire.valid && retire.wr_flags) ? FLAGS_OUT : FLAGS_REG;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            FLAGS_REG <= '0;
        end else if (commit && retire.wr_flags) begin
            FLAGS_REG <= FLAGS_OUT;
        end
    end

    // Only stages younger than the retiring one can stall; the retiring one is bypassable.
    always_comb begin
        raw_hazard  = 1'b0;
        flag_hazard = 1'b0;
        PENDING_CNT = '0;
        for (int unsigned i = 0; i < PIPE_DEPTH - 1; i++) begin
            if (stage[i].valid) begin
                if (stage[i].wr_reg &&
                    (stage[i].dest == SRC_A_ADDR || stage[i].dest == SRC_B_ADDR)) begin
                    raw_hazard = 1'b1;
                end
                if (stage[i].wr_flags) begin
                    flag_hazard = 1'b1;
                end
            end
        end
        for (int unsigned i = 0; i < PIPE_DEPTH; i++) begin
            PENDING_CNT = PENDING_CNT + {1'b0, stage[i].valid};
        end
    end

    assign HAZARD   = raw_hazard | flag_hazard;
    assign BYPASS_A = retire.valid & retire.wr_reg & (retire.dest == SRC_A_ADDR) & ~HAZARD;
    assign BYPASS_B = retire.valid & retire.wr_reg & (retire.dest == SRC_B_ADDR) & ~HAZARD;

endmodule

// File: doc/bcpu_alu_writeback.md
Name: bcpu_alu_writeback

Overview:
- Result-consuming end of the bcpu 3-stage DSP48E1 ALU pipeline.
- Tracks the destination register and flag-write intent of each issued ALU op through a CE-gated tag pipeline aligned with the ALU latency.
- Generates the register-file write port, holds the architectural {V,S,Z,C} flags register, and reports RAW hazards and bypass selects to the issue stage.

Parameters:
- DATA_WIDTH, 16, ALU data width.
- REG_ADDR_WIDTH, 3, register address width.
- PIPE_DEPTH, 3, ALU latency in CE-enabled clocks; fixed at 3.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RESET  in  1  synchronous reset, active-high.
- CE  in  1  pipeline step enable, shared with the ALU.
- ISSUE_EN  in  1  ALU op issued this cycle (same cycle and meaning as ALU_EN).
- ISSUE_DEST  in  REG_ADDR_WIDTH  destination register of the issued op.
- ISSUE_WR_REG  in  1  issued op writes a register.
- ISSUE_WR_FLAGS  in  1  issued op updates the flags.
- SRC_A_ADDR  in  REG_ADDR_WIDTH  operand A register of the instruction being decoded.
- SRC_B_ADDR  in  REG_ADDR_WIDTH  operand B register of the instruction being decoded.
- ALU_OUT  in  DATA_WIDTH  ALU result.
- FLAGS_OUT  in  4  ALU output flags {V,S,Z,C}.
- REG_WE  out  1  register-file write enable.
- REG_WADDR  out  REG_ADDR_WIDTH  write address.
- REG_WDATA  out  DATA_WIDTH  write data; equals ALU_OUT.
- FLAGS_REG  out  4  architectural flags.
- FLAGS_NEXT  out  4  flags value to feed the ALU FLAGS_IN (bypassed).
- HAZARD  out  1  operand or flag RAW stall request.
- BYPASS_A  out  1  operand A must take ALU_OUT instead of the register file.
- BYPASS_B  out  1  operand B must take ALU_OUT instead of the register file.
- PENDING_CNT  out  2  number of valid in-flight ops (0..3).

Behaviour:
- Tag pipeline: stages s0..s2, each holding {valid, dest, wr_reg, wr_flags}.
- Advances only on posedge with CE=1: s0 <= issue fields (valid = ISSUE_EN), s1 <= s0, s2 <= s1.
- CE=0: all stages hold; ISSUE_EN is ignored.
- s2 lines up with ALU_OUT/FLAGS_OUT: an op issued at edge N (CE high) produces its result during the cycle after the third CE-enabled edge.
- Commit (combinational): REG_WE = CE & s2.valid & s2.wr_reg; REG_WADDR = s2.dest; REG_WDATA = ALU_OUT.
  - The write takes effect exactly once, at the edge where s2 retires.
  - CE=0 blocks the write, so a paused result is never duplicated or lost.
- FLAGS_REG: on posedge with CE & s2.valid & s2.wr_flags, load FLAGS_OUT; otherwise hold.
- FLAGS_NEXT = (s2.valid & s2.wr_flags) ? FLAGS_OUT : FLAGS_REG.
- Hazard and bypass (combinational):
  - HAZARD = 1 if any valid s0/s1 with wr_reg and dest equal to SRC_A_ADDR or SRC_B_ADDR.
  - HAZARD also = 1 if any valid s0/s1 has wr_flags.
  - BYPASS_A = s2.valid & s2.wr_reg & (s2.dest == SRC_A_ADDR) & !HAZARD; BYPASS_B likewise.
  - The younger stage wins: a match in s0/s1 raises HAZARD even if s2 also matches.
- PENDING_CNT = popcount of valid s0..s2.
- Simultaneous issue and retire on one edge are independent; the count may stay constant.
- Reset (synchronous, wins over CE): all valid=0, FLAGS_REG=0, hence REG_WE=0, HAZARD=0, BYPASS_*=0, PENDING_CNT=0.
  - Mid-operation, in-flight ops are discarded with no write, even when CE=1 on the reset edge.
- Issuing while HAZARD=1 is the issuer's error; the block still tracks the op and does not check for it.

Decomposition:
- bcpu_defs gains: flags bit index constants FLAG_C=0, FLAG_Z=1, FLAG_S=2, FLAG_V=3; ALU_LATENCY=3; a packed struct alu_wb_tag_t {valid, dest, wr_reg, wr_flags}.
- Natural sub-module: bcpu_alu_wb_tagpipe, the CE-gated 3-entry tag shift register exposing all stages.
- Hazard, bypass and commit logic stay in the top module.

Test Plan:
- Issue ADD dest=R2, wr_reg=1, wr_flags=1, CE=1 continuously; ALU_OUT=33, FLAGS_OUT=0000 -> REG_WE=1, REG_WADDR=2, REG_WDATA=33 exactly in the 3rd cycle after issue; FLAGS_REG=0000 after that edge.
- Issue to R5 then hold CE=0 for 3 cycles after 1 step -> REG_WE stays 0 while paused, PENDING_CNT=1; write to R5 occurs once after 2 further CE cycles.
- Issue R1 at cycle 0; SRC_A_ADDR=1 -> HAZARD=1 in cycles 1-2; cycle 3 HAZARD=0, BYPASS_A=1, BYPASS_B=0; cycle 4 both 0.
- SUB with wr_flags, FLAGS_OUT=0101 at retire, FLAGS_REG=1111 before -> FLAGS_NEXT=0101 in the retire cycle, FLAGS_REG=0101 next; a non-flag op retiring later leaves FLAGS_REG=0101.
- Back-to-back issue R1, R2, R3 -> PENDING_CNT 1, 2, 3, then holds 3 while issuing continues; writes to R1, R2, R3 on consecutive cycles.
- Three ops in flight, RESET=1 with CE=1 for one edge -> no REG_WE; PENDING_CNT=0, FLAGS_REG=0000 next cycle.
